// File: rtl/inv_key_schedule_pkg.sv
// rtl/inv_key_schedule_pkg.sv - shared rcon table and schedule state encoding
package inv_key_schedule_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam int NUM_ROUNDS = 10;

    // rcon[1] in the top byte, rcon[10] in the bottom byte
    localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

    function automatic logic [31:0] rcon_word(input logic [3:0] rnd);
        logic [7:0] rc;
        rc = '0;
        for (int i = 1; i <= NUM_ROUNDS; i++) begin
            if (rnd == 4'(i)) rc = RCON_TABLE[(NUM_ROUNDS - i) * 8 +: 8];
        end
        return {rc, 24'h000000};
    endfunction

endpackage

// File: rtl/inv_key_schedule_sbytes.sv
// rtl/inv_key_schedule_sbytes.sv - AES SubBytes over NWords 32-bit words
module inv_key_schedule_sbytes #(
    parameter int NWords = 1
) (
    input  logic [32*NWords-1:0] data,
    output logic [32*NWords-1:0] result
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        localparam logic [7:0] EXP = 8'hfe;
        logic [7:0] inv;
        logic [7:0] pw;
        inv = 8'h01;
        pw  = a;
        for (int i = 0; i < 8; i++) begin
            if (EXP[i]) inv = gf_mul(inv, pw);
            pw = gf_mul(pw, pw);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    for (genvar b = 0; b < 4 * NWords; b++) begin : g_byte
        assign result[8*b +: 8] = sbox(data[8*b +: 8]);
    end

endmodule

// File: rtl/inv_key_schedule.sv
// rtl/inv_key_schedule.sv - AES-128 round keys delivered in reverse order 10..0
module inv_key_schedule
    import inv_key_schedule_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10,
    parameter int Nb = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] keyIn,
    input  logic         outReady,
    output logic         roundKeyValid,
    output logic [127:0] roundKey,
    output logic [3:0]   roundIdx,
    output logic         busy,
    output logic         done
);

    if (Nk != 4 || Nr != NUM_ROUNDS || Nb != 4) begin : g_bad_param
        $error("inv_key_schedule supports only AES-128 (Nk=4, Nr=10, Nb=4)");
    end

    state_t        state;
    state_t        state_next;
    logic [127:0]  rk;
    logic [3:0]    rnd;
    logic          done_q;
    logic          handshake;

    logic [31:0]   a0, a1, a2, a3;
    logic [31:0]   sub_in, sub_out;
    logic [31:0]   f0, f1, f2, f3;
    logic [31:0]   i0, i1, i2, i3;

    assign a0 = rk[127:96];
    assign a1 = rk[95:64];
    assign a2 = rk[63:32];
    assign a3 = rk[31:0];

    // One SubWord serves both directions; the backward step needs the recovered w3
    assign sub_in = (state == FWD) ? a3 : (a3 ^ a2);

    inv_key_schedule_sbytes #(.NWords(1)) u_sbytes (
        .data   ({sub_in[23:0], sub_in[31:24]}),
        .result (sub_out)
    );

    assign f0 = a0 ^ sub_out ^ rcon_word(4'(rnd + 4'd1));
    assign f1 = a1 ^ f0;
    assign f2 = a2 ^ f1;
    assign f3 = a3 ^ f2;

    assign i3 = a3 ^ a2;
    assign i2 = a2 ^ a1;
    assign i1 = a1 ^ a0;
    assign i0 = a0 ^ sub_out ^ rcon_word(rnd);

    assign roundKeyValid = (state == EMIT);
    assign handshake     = roundKeyValid && outReady;
    assign roundKey      = roundKeyValid ? rk : '0;
    assign roundIdx      = roundKeyValid ? rnd : '0;
    assign busy          = (state != IDLE);
    assign done          = done_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FWD;
            FWD:     if (rnd == 4'(NUM_ROUNDS - 1)) state_next = EMIT;
            EMIT:    if (handshake && rnd == 4'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rk     <= '0;
            rnd    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= handshake && (rnd == 4'd0);
            case (state)
                IDLE: begin
                    if (start) begin
                        rk  <= keyIn;
                        rnd <= '0;
                    end
                end
                FWD: begin
                    rk  <= {f0, f1, f2, f3};
                    rnd <= rnd + 4'd1;
                end
                EMIT: begin
                    if (handshake && rnd != 4'd0) begin
                        rk  <= {i0, i1, i2, i3};
                        rnd <= rnd - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/inv_key_schedule.md
Name: inv_key_schedule

Overview:
- Decrypt-side counterpart of the encrypt key expansion. Takes the AES-128 cipher key and delivers round keys in reverse order, 10 down to 0, one per valid/ready handshake, for the decrypt round datapath.
- Iterative rather than fully unrolled: one round-key register plus a shared single-word SubBytes. Forward walk to round key 10, then backward derivation on each accepted output.

Parameters:
- Nk, 4, key length in words; only 4 is supported (generate-time error otherwise).
- Nr, 10, number of rounds; only 10 is supported.
- Nb, 4, block size in words.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a new schedule; sampled only in IDLE.
- keyIn  in  128  cipher key, w0 in [127:96]; captured on the start edge.
- outReady  in  1  consumer accepts roundKey this cycle.
- roundKeyValid  out  1  roundKey/roundIdx are valid.
- roundKey  out  128  current round key, word 0 in [127:96].
- roundIdx  out  4  round number of roundKey (10..0).
- busy  out  1  high in FWD and EMIT.
- done  out  1  one-cycle pulse after round key 0 is accepted.

Behaviour:
- Reset values: all registers cleared; state=IDLE; roundKeyValid=0, roundKey=0, roundIdx=0, busy=0, done=0.
- rst is synchronous, active-high, and has priority over every other input. It aborts any schedule mid-operation and returns to IDLE with reset values, and no done pulse is issued.
- States:
  - IDLE: if start=1, set rk<=keyIn, rnd<=0, go to FWD. Otherwise hold.
  - FWD: each edge, rk<=fwd(rk, rcon[rnd+1]) and rnd<=rnd+1. At the edge producing round 10, go to EMIT with roundIdx=10.
  - EMIT: roundKeyValid=1.
    - Handshake is outReady&&roundKeyValid.
    - On handshake with roundIdx>0: rk<=inv(rk, rcon[roundIdx]), roundIdx<=roundIdx-1, stay in EMIT.
    - On handshake with roundIdx==0: go to IDLE, done=1 for one cycle.
- fwd(a, rc):
  - b0 = a0 ^ SubWord(RotWord(a3)) ^ rc
  - b1 = a1 ^ b0, b2 = a2 ^ b1, b3 = a3 ^ b2
- inv(a, rc), with a = round key r and rc = rcon[r]:
  - b3 = a3 ^ a2, b2 = a2 ^ a1, b1 = a1 ^ a0
  - b0 = a0 ^ SubWord(RotWord(b3)) ^ rc
- RotWord rotates bytes left by one: {w[23:0], w[31:24]}.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, each in the top byte of the word.
- One SBytes instance only. Its input is muxed: a3 in FWD, (a3^a2) in EMIT.
- Latency: with start sampled at edge E0, roundKeyValid=1 from edge E10. With outReady held high, round key k is presented at edge E10+(10-k), and done is high after edge E21.
- Backpressure: while roundKeyValid=1 and outReady=0, roundKey and roundIdx are held stable.
- roundKey reads 0 whenever roundKeyValid=0.
- start in FWD or EMIT is ignored, and keyIn is not re-sampled.
- start in the cycle where done=1: the state is IDLE, so start is accepted normally.
- busy = (state != IDLE).

Decomposition:
- Shared package: rcon table (10 x 8-bit) and the state encoding (IDLE, FWD, EMIT). The encrypt KeyExpansion switches to the same rcon table.
- Sub-module: the existing SBytes with NWords=1. No other sub-modules.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, outReady=1 → round key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at roundIdx=10 exactly 10 cycles after start. Keys then follow in order down to round 1 = a0fafe1788542cb123a339392a6c7605 and round 0 = the input key. done pulses once.
- Same key, outReady toggled pseudo-randomly → all 11 keys are delivered in order. roundKey and roundIdx never change while valid=1 and outReady=0.
- start pulsed during FWD and during EMIT with a different keyIn → no effect; the output sequence still matches the first key.
- rst asserted at roundIdx=6 → next cycle all outputs are 0 and state is IDLE. A new start with key 000102030405060708090a0b0c0d0e0f → round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- start asserted in the done cycle → a second schedule begins with no idle gap. valid rises 10 cycles later.
- Reference-model compare: 1000 random keys against the encrypt KeyExpansion's round keys, checked in reverse order.
